if_id_stall_ctrl: RTL and testbench
===================================

// Module: if_id_stall_ctrl
// PURPOSE
// - Consumer side of the load-use hazard handshake: takes Stall from the Hazzard unit and Flush from
//   branch resolution, and acts on them.
// - Holds the IF/ID pipeline register (PC and instruction).
// - Gates PC update and injects a bubble into the ID/EX control bundle.
// - Sits between fetch, decode and the ID/EX register of the 5-stage ARMv8 pipeline.
// PARAMETERS
// PC_W      64  PC width
// INSTR_W   32  instruction width
// CTRL_W    9   decoded control bundle width (Reg2Loc..RegWrite)
// CNT_W     16  stall/flush counter width
// MAX_STALL 3   consecutive stall cycles before StallErr asserts
// PORTS
// clk        in   1        rising-edge clock
// rst_n      in   1        asynchronous reset, active low
// Stall      in   1        load-use stall request from Hazzard (combinational, sampled at clk)
// Flush      in   1        branch taken in MEM; squash IF/ID and ID/EX control
// PC_in      in   PC_W     PC of the instruction being fetched
// Instr_in   in   INSTR_W  instruction being fetched
// Ctrl_in    in   CTRL_W   control bundle decoded from Instr_out
// PCWrite    out  1        PC register enable (combinational)
// PC_out     out  PC_W     IF/ID PC
// Instr_out  out  INSTR_W  IF/ID instruction
// Valid_out  out  1        IF/ID holds a live instruction
// CtrlEX     out  CTRL_W   registered ID/EX control bundle (zero = bubble)
// StallCnt   out  CNT_W    total stall cycles, saturating
// FlushCnt   out  CNT_W    total flush cycles, saturating
// StallErr   out  1        sticky; stall lasted more than MAX_STALL consecutive cycles
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - PC_out=0, Instr_out=0, Valid_out=0, CtrlEX=0.
//   - StallCnt=0, FlushCnt=0, StallErr=0.
//   - State=RUN, run-length counter=0.
//   - Release is synchronous to the next clk edge.
// - PCWrite = ~(Stall & ~Flush), combinational. During reset, PCWrite=1.
// - Priority per cycle: Flush > Stall > normal.
// - Normal (Stall=0, Flush=0):
//   - IF/ID <= {PC_in, Instr_in}, Valid_out<=1.
//   - CtrlEX <= Ctrl_in, masked to 0 when Valid_out=0.
// - Stall=1, Flush=0:
//   - IF/ID holds (PC_out, Instr_out and Valid_out unchanged).
//   - CtrlEX<=0 (bubble); StallCnt++.
//   - Latency: the bubble is visible in CtrlEX the cycle after Stall is sampled.
// - Flush=1 (Stall don't-care):
//   - Instr_out<=0, Valid_out<=0 (PC_out also cleared to 0).
//   - CtrlEX<=0; FlushCnt++.
//   - Stall is ignored and StallCnt does not increment.
// - FSM {RUN, STALL, FLUSH}, registered, encoded 2 bits:
//   - RUN -> STALL on Stall&~Flush.
//   - Any state -> FLUSH on Flush.
//   - STALL -> STALL while Stall&~Flush; run-length++.
//   - STALL/FLUSH -> RUN when Stall=0 and Flush=0.
//   - Run-length clears on leaving STALL.
//   - StallErr sets when run-length reaches MAX_STALL while Stall is still 1 (i.e. the
//     MAX_STALL+1-th consecutive stall). It stays set until reset.
// - Counters saturate at {CNT_W{1'b1}} and never wrap.
// - Mid-operation reset: all state is cleared immediately; no partial bubble survives.
// - Ctrl_in is always combinationally valid, so no ready/valid handshake is needed.
// STRUCTURE
// - Shared package arm_pipe_pkg:
//   - State enum (RUN=0, STALL=1, FLUSH=2).
//   - CTRL_W.
//   - CTRL_BUBBLE = '0.
// - One sub-module: sat_counter (CNT_W, inc, rst_n) -> count.
//   - Instantiated twice, for StallCnt and FlushCnt.
// - IF/ID register, ID/EX control register and FSM stay inline.
// TESTING
// - Reset then PC_in=4, Instr_in=32'h8B020020, Ctrl_in=9'h0A2, Stall=0:
//   - Next edge: PC_out=4, Valid_out=1, PCWrite=1.
//   - Following edge: CtrlEX=9'h0A2.
// - Stall=1 for 1 cycle with PC_in=8:
//   - PCWrite=0 and PC_out stays 4.
//   - CtrlEX=0 for 1 cycle, then StallCnt=1.
// - Stall=1 and Flush=1 in the same cycle:
//   - PCWrite=1, Valid_out=0, CtrlEX=0.
//   - FlushCnt=1, StallCnt unchanged.
// - Stall held 4 cycles with MAX_STALL=3:
//   - StallErr rises on the 4th stall edge.
//   - StallErr stays 1 after Stall drops; StallCnt=4.
// - Force StallCnt to 16'hFFFE, then 3 stall cycles:
//   - StallCnt reaches 16'hFFFF and stays there.
// - rst_n=0 asserted mid-stall, between edges:
//   - All outputs clear immediately.
//   - After release the FSM is in RUN and the first fetch is latched normally.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARMv8 5-stage pipeline control blocks.
//   pipe_state_e : IF/ID stall controller state encoding (2 bits)
//   CTRL_W       : width of the decoded control bundle (Reg2Loc..RegWrite)
//   CTRL_BUBBLE  : control bundle value that turns an ID/EX slot into a no-op
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } pipe_state_e;

  localparam int CTRL_W = 9;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/if_id_stall_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline event statistics.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low (clears count)
//   inc   : increment request for this cycle
//   count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline register with load-use stall and branch-flush handling.
// Holds fetched PC/instruction, gates the PC register, and injects bubbles
// into the ID/EX control bundle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   Stall, Flush        : hazard stall request, branch-taken squash (Flush wins)
//   PC_in, Instr_in     : fetch-stage PC and instruction
//   Ctrl_in             : control bundle decoded from Instr_out
//   PCWrite             : PC register enable (combinational)
//   PC_out, Instr_out   : IF/ID register contents
//   Valid_out           : IF/ID holds a live instruction
//   CtrlEX              : registered ID/EX control bundle (zero = bubble)
//   StallCnt, FlushCnt  : saturating event counters
//   StallErr            : sticky; a stall ran longer than MAX_STALL cycles
//
// state    | meaning
// ST_RUN   | normal fetch/decode flow
// ST_STALL | load-use stall in progress, run_len counts consecutive stalls
// ST_FLUSH | IF/ID and ID/EX control squashed by a taken branch
module if_id_stall_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int PC_W      = 64,
  parameter int INSTR_W   = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Stall,
  input  logic               Flush,
  input  logic [PC_W-1:0]    PC_in,
  input  logic [INSTR_W-1:0] Instr_in,
  input  logic [CTRL_W-1:0]  Ctrl_in,
  output logic               PCWrite,
  output logic [PC_W-1:0]    PC_out,
  output logic [INSTR_W-1:0] Instr_out,
  output logic               Valid_out,
  output logic [CTRL_W-1:0]  CtrlEX,
  output logic [CNT_W-1:0]   StallCnt,
  output logic [CNT_W-1:0]   FlushCnt,
  output logic               StallErr
);

  localparam int RL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);

  logic            stall_now;
  pipe_state_e     state, state_nxt;
  logic [RL_W-1:0] run_len, run_len_nxt;
  logic            err_nxt;

  // A flush overrides any stall request in the same cycle.
  assign stall_now = Stall & ~Flush;

  // The PC must keep advancing out of reset, hence the rst_n term.
  assign PCWrite = ~rst_n | ~stall_now;

  // IF/ID and ID/EX control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_out    <= '0;
      Instr_out <= '0;
      Valid_out <= 1'b0;
      CtrlEX    <= CTRL_BUBBLE;
    end else if (Flush) begin
      PC_out    <= '0;
      Instr_out <= '0;
      Valid_out <= 1'b0;
      CtrlEX    <= CTRL_BUBBLE;
    end else if (Stall) begin
      CtrlEX    <= CTRL_BUBBLE;
    end else begin
      PC_out    <= PC_in;
      Instr_out <= Instr_in;
      Valid_out <= 1'b1;
      // Ctrl_in is decoded from Instr_out; an empty slot must not issue.
      CtrlEX    <= Valid_out ? Ctrl_in : CTRL_BUBBLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      run_len  <= '0;
      StallErr <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_len  <= run_len_nxt;
      StallErr <= err_nxt;
    end
  end

  // FSM next state; run_len counts stall edges so far in the current run,
  // so the error fires on stall number MAX_STALL+1.
  always_comb begin
    state_nxt   = state;
    run_len_nxt = run_len;
    err_nxt     = StallErr;
    case (state)
      ST_RUN, ST_FLUSH: begin
        run_len_nxt = '0;
        if (Flush) begin
          state_nxt = ST_FLUSH;
        end else if (Stall) begin
          state_nxt = ST_STALL;
          if (RL_MAX == '0) err_nxt = 1'b1;
          else              run_len_nxt = RL_W'(1);
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_STALL: begin
        if (Flush) begin
          state_nxt   = ST_FLUSH;
          run_len_nxt = '0;
        end else if (Stall) begin
          if (run_len >= RL_MAX) err_nxt = 1'b1;
          else                   run_len_nxt = run_len + 1'b1;
        end else begin
          state_nxt   = ST_RUN;
          run_len_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_RUN;
        run_len_nxt = '0;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_now),
    .count (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (Flush),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
`timescale 1ns/1ps
module tb_if_id_stall_ctrl;

  localparam logic [31:0] I1 = 32'h8B020020;
  localparam logic [31:0] I2 = 32'hF9400041;
  localparam logic [31:0] I3 = 32'hCB030062;
  localparam logic [31:0] I4 = 32'hD503201F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall, Flush;
  logic [63:0] PC_in;
  logic [31:0] Instr_in;
  logic [8:0]  Ctrl_in;
  logic        PCWrite;
  logic [63:0] PC_out;
  logic [31:0] Instr_out;
  logic        Valid_out;
  logic [8:0]  CtrlEX;
  logic [15:0] StallCnt, FlushCnt;
  logic        StallErr;

  if_id_stall_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Stall     (Stall),
    .Flush     (Flush),
    .PC_in     (PC_in),
    .Instr_in  (Instr_in),
    .Ctrl_in   (Ctrl_in),
    .PCWrite   (PCWrite),
    .PC_out    (PC_out),
    .Instr_out (Instr_out),
    .Valid_out (Valid_out),
    .CtrlEX    (CtrlEX),
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt),
    .StallErr  (StallErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pcw;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [8:0]  ctrl;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  event imm_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string item, input string field,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", item, field, act, req);
    end
  endtask

  // Monitor: outputs are sampled 1ns after each clock edge, or right after
  // an asynchronous event the driver announces on imm_ev.
  initial begin
    forever begin
      @(posedge clk or imm_ev);
      #1;
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        cmp(cur.name, "PCWrite",   64'(PCWrite),   64'(cur.pcw));
        cmp(cur.name, "PC_out",    PC_out,         cur.pc);
        cmp(cur.name, "Instr_out", 64'(Instr_out), 64'(cur.instr));
        cmp(cur.name, "Valid_out", 64'(Valid_out), 64'(cur.valid));
        cmp(cur.name, "CtrlEX",    64'(CtrlEX),    64'(cur.ctrl));
        cmp(cur.name, "StallCnt",  64'(StallCnt),  64'(cur.scnt));
        cmp(cur.name, "FlushCnt",  64'(FlushCnt),  64'(cur.fcnt));
        cmp(cur.name, "StallErr",  64'(StallErr),  64'(cur.err));
      end
    end
  end

  task automatic drive(input logic st, input logic fl, input logic [63:0] pc,
                       input logic [31:0] ins, input logic [8:0] ct);
    Stall    = st;
    Flush    = fl;
    PC_in    = pc;
    Instr_in = ins;
    Ctrl_in  = ct;
  endtask

  task automatic push(input string nm, input logic pcw, input logic [63:0] pc,
                      input logic [31:0] instr, input logic valid, input logic [8:0] ctrl,
                      input logic [15:0] scnt, input logic [15:0] fcnt, input logic err);
    exp_t e;
    e.name = nm; e.pcw = pcw; e.pc = pc; e.instr = instr; e.valid = valid;
    e.ctrl = ctrl; e.scnt = scnt; e.fcnt = fcnt; e.err = err;
    sb.push_back(e);
  endtask

  // One clocked vector: inputs applied at a falling edge, expectation for the
  // following rising edge queued, then advance to the next falling edge.
  task automatic cyc(input string nm, input logic st, input logic fl,
                     input logic [63:0] pci, input logic [31:0] insi, input logic [8:0] cti,
                     input logic pcw, input logic [63:0] pc, input logic [31:0] instr,
                     input logic valid, input logic [8:0] ctrl,
                     input logic [15:0] scnt, input logic [15:0] fcnt, input logic err);
    drive(st, fl, pci, insi, cti);
    push(nm, pcw, pc, instr, valid, ctrl, scnt, fcnt, err);
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 32'd0, 9'd0);
    @(negedge clk);
    // PCWrite must stay high during reset even with Stall raised
    drive(1'b1, 1'b0, 64'd0, 32'd0, 9'd0);
    push("reset", 1'b1, 64'd0, 32'd0, 1'b0, 9'd0, 16'd0, 16'd0, 1'b0);
    -> imm_ev;
    #2;
    @(negedge clk);
    rst_n = 1'b1;

    cyc("fetch0",  0,0, 64'd4,  I1, 9'h0A2,  1, 64'd4,  I1, 1, 9'h000, 16'd0, 16'd0, 0);
    cyc("fetch1",  0,0, 64'd4,  I1, 9'h0A2,  1, 64'd4,  I1, 1, 9'h0A2, 16'd0, 16'd0, 0);
    cyc("stall1",  1,0, 64'd8,  I2, 9'h0A2,  0, 64'd4,  I1, 1, 9'h000, 16'd1, 16'd0, 0);
    cyc("resume",  0,0, 64'd8,  I2, 9'h155,  1, 64'd8,  I2, 1, 9'h155, 16'd1, 16'd0, 0);
    cyc("stflush", 1,1, 64'd12, I3, 9'h155,  1, 64'd0,  32'd0, 0, 9'h000, 16'd1, 16'd1, 0);
    cyc("refetch", 0,0, 64'd16, I3, 9'h1FF,  1, 64'd16, I3, 1, 9'h000, 16'd1, 16'd1, 0);
    cyc("decode",  0,0, 64'd16, I3, 9'h1FF,  1, 64'd16, I3, 1, 9'h1FF, 16'd1, 16'd1, 0);
    for (int i = 0; i < 3; i++)
      cyc("run3",  1,0, 64'd20, I4, 9'h1FF,  0, 64'd16, I3, 1, 9'h000, 16'(2+i), 16'd1, 0);
    cyc("after3",  0,0, 64'd20, I4, 9'h0A2,  1, 64'd20, I4, 1, 9'h0A2, 16'd4, 16'd1, 0);
    for (int i = 0; i < 4; i++)
      cyc("run4",  1,0, 64'd24, I1, 9'h0A2,  0, 64'd20, I4, 1, 9'h000, 16'(5+i), 16'd1,
          (i == 3) ? 1'b1 : 1'b0);
    cyc("after4",  0,0, 64'd24, I1, 9'h0A2,  1, 64'd24, I1, 1, 9'h0A2, 16'd8, 16'd1, 1);
    for (int i = 0; i < 2; i++)
      cyc("flush2", 0,1, 64'd28, I2, 9'h0A2, 1, 64'd0,  32'd0, 0, 9'h000, 16'd8, 16'(2+i), 1);
    cyc("postfl",  0,0, 64'd32, I3, 9'h0A2,  1, 64'd32, I3, 1, 9'h000, 16'd8, 16'd3, 1);

    // Unchecked stall stretch bringing StallCnt from 8 to 16'hFFFE
    drive(1'b1, 1'b0, 64'd36, I4, 9'h0A2);
    for (int i = 0; i < 65526; i++) @(negedge clk);
    for (int i = 0; i < 3; i++)
      cyc("sat",   1,0, 64'd36, I4, 9'h0A2,  0, 64'd32, I3, 1, 9'h000, 16'hFFFF, 16'd3, 1);

    // Reset asserted mid-stall, between clock edges
    rst_n = 1'b0;
    push("midrst", 1'b1, 64'd0, 32'd0, 1'b0, 9'd0, 16'd0, 16'd0, 1'b0);
    -> imm_ev;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("relfetch", 0,0, 64'd40, I4, 9'h0A2, 1, 64'd40, I4, 1, 9'h000, 16'd0, 16'd0, 0);
    for (int i = 0; i < 3; i++)
      cyc("relrun3", 1,0, 64'd44, I1, 9'h0A2, 0, 64'd40, I4, 1, 9'h000, 16'(1+i), 16'd0, 0);
    cyc("relres",  0,0, 64'd44, I1, 9'h0A2,  1, 64'd44, I1, 1, 9'h0A2, 16'd3, 16'd0, 0);

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
